ecc_apb_sequencer: RTL and testbench
====================================

# ecc_apb_sequencer

APB-master sequencer that drives the ECC encoder/decoder block for one request at a time. It accepts an operation request from the stimulus/host side and programs the DATA_IN, CODEWORD_WIDTH, NOISE and CTRL registers over APB. It then waits for `operation_done` and returns `data_out` and `num_of_errors` as a single-cycle response. It sits between a host/test sequencer and the `ecc_enc_dec` APB slave.

## Interface
- `AMBA_ADDR_WIDTH`, 32, APB address width
- `AMBA_WORD`, 32, APB data width
- `DATA_WIDTH`, 32, payload width; must be ≤ `AMBA_WORD`
- `TIMEOUT_CYCLES`, 1024, maximum WAIT_DONE cycles before abort; ≥ 1
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-low reset
- `req_valid` in 1: request present
- `req_ready` out 1: sequencer idle and accepting
- `req_op` in 2: 0 = nothing, 1 = encode, 2 = decode, 3 = full channel
- `req_data` in DATA_WIDTH: data word or codeword
- `req_width` in 2: CODEWORD_WIDTH register value
- `req_noise` in DATA_WIDTH: NOISE register value
- `paddr` out AMBA_ADDR_WIDTH: APB address
- `pwdata` out AMBA_WORD: APB write data, zero-extended
- `psel`, `penable`, `pwrite` out 1 each: APB control
- `operation_done` in 1: ECC completion strobe
- `data_out` in DATA_WIDTH: ECC result
- `num_of_errors` in 2: ECC error count
- `rsp_valid` out 1: one-cycle response strobe
- `rsp_data` out DATA_WIDTH: captured `data_out`
- `rsp_num_of_errors` out 2: captured `num_of_errors`
- `rsp_timeout` out 1: response is a timeout abort
- `rsp_err` out 1: response is an illegal-op reject

## Operation
- Register map (byte addresses):
  - CTRL 0x00
  - DATA_IN 0x04
  - CODEWORD_WIDTH 0x08
  - NOISE 0x0C
- CTRL value is `req_op - 1`, i.e. 0 = encode, 1 = decode, 2 = full channel.
- Write order is fixed: DATA_IN, CODEWORD_WIDTH, NOISE, CTRL. The CTRL write is the trigger.
- A request is accepted on `req_valid & req_ready`. All `req_*` fields are latched on that edge.
- `req_op == 0`: no APB traffic; go directly to RESP with `rsp_err` = 1.
- FSM states and transitions:
  - IDLE → SETUP on accept, or → RESP on op 0.
  - SETUP → ACCESS.
  - ACCESS → SETUP for the next register, or → WAIT_DONE after the CTRL write.
  - WAIT_DONE → RESP on `operation_done`, or when the timeout counter reaches `TIMEOUT_CYCLES`.
  - RESP → IDLE.
- SETUP: `psel` = 1, `penable` = 0, `pwrite` = 1, `paddr`/`pwdata` valid.
- ACCESS: same as SETUP but `penable` = 1. The slave has no `pready`, so every access is exactly 2 cycles.
- In IDLE, WAIT_DONE and RESP: `psel`, `penable`, `pwrite`, `paddr`, `pwdata` are all 0.
- `operation_done` is ignored outside WAIT_DONE (stale strobes are dropped).
- `data_out` and `num_of_errors` are captured in the cycle `operation_done` is high in WAIT_DONE.
- On timeout: `rsp_timeout` = 1, `rsp_data` = 0, `rsp_num_of_errors` = 0.
- `rsp_*` payload holds its value until the next response. `rsp_valid` is high for exactly one cycle.
- `req_ready` is 1 only in IDLE.
- Timeout counter: width `$clog2(TIMEOUT_CYCLES+1)`, cleared on entry to WAIT_DONE, saturates and does not wrap.

## Timing
- Reset (`rst` = 0 at a clock edge): FSM → IDLE. All outputs 0, including `req_ready`. The timeout counter and cache are cleared.
- `req_ready` rises the first cycle after `rst` goes high.
- Reset mid-transaction aborts immediately: `psel` is low the next cycle and no response is issued.
- Accept at edge T:
  - DATA_IN SETUP/ACCESS at T+1/T+2
  - CODEWORD_WIDTH at T+3/T+4
  - NOISE at T+5/T+6
  - CTRL at T+7/T+8
  - WAIT_DONE from T+9
- `operation_done` first seen at cycle D → `rsp_valid` at D+1 → IDLE at D+2, which is the earliest next accept.
- Timeout: `rsp_valid` occurs `TIMEOUT_CYCLES`+1 cycles after WAIT_DONE entry.
- Op 0 accepted at T: `rsp_valid` with `rsp_err` at T+1.
- `operation_done` in the same cycle the counter hits its limit: done wins, `rsp_timeout` = 0.

## Configuration
- `ECC_SEQ_REG_CACHE_EN` defined:
  - The sequencer keeps the last written CODEWORD_WIDTH and NOISE values plus a valid bit.
  - Each register write is skipped when its value is unchanged and the valid bit is set.
  - With both skipped, CTRL SETUP is at T+3, ACCESS at T+4, WAIT_DONE from T+5.
  - The valid bit is cleared by reset and by a timeout response.
- Not defined: all four writes on every transaction, with timing exactly as above.

## Test plan
- Encode: `req_op`=1, `req_data`=0x5A, `req_width`=0 → four APB writes at addresses 0x04, 0x08, 0x0C, 0x00 with CTRL `pwdata`=0. Model raises done at T+12 → `rsp_valid` at T+13 with `rsp_data` = model `data_out`.
- Decode with 1 error: `req_op`=2, model returns `num_of_errors`=1 → `rsp_num_of_errors`=1, `rsp_timeout`=0, `rsp_err`=0.
- Timeout: `TIMEOUT_CYCLES`=8, no done → `rsp_valid` 9 cycles after WAIT_DONE entry, `rsp_timeout`=1, `rsp_data`=0.
- Op 0 and stale done: `req_op`=0 → `rsp_err`=1 at T+1 with `psel` never high. Done pulsed during the write phase → ignored; the response waits for a done inside WAIT_DONE.
- Reset mid-ACCESS: `rst` low during NOISE ACCESS → next cycle `psel`=`penable`=0, `req_ready`=0, no `rsp_valid`. After release, a new request runs the full sequence.
- `ECC_SEQ_REG_CACHE_EN`: two back-to-back requests with the same width and noise → the second issues only DATA_IN and CTRL writes. A third request with new noise writes NOISE again.

Source files
------------

// File: rtl/ecc_apb_sequencer_if.sv
// ecc_apb_sequencer_if
//   Groups every non-clock signal of the ECC APB sequencer. The sequencer
//   uses the master modport. A host/bench that drives requests and plays the
//   ECC slave uses the slave modport.
//   Request side : req_valid, req_ready, req_op, req_data, req_width, req_noise
//   APB side     : paddr, pwdata, psel, penable, pwrite
//   ECC status   : operation_done, data_out, num_of_errors
//   Response     : rsp_valid, rsp_data, rsp_num_of_errors, rsp_timeout, rsp_err
interface ecc_apb_sequencer_if #(
   parameter int AMBA_ADDR_WIDTH = 32,
   parameter int AMBA_WORD       = 32,
   parameter int DATA_WIDTH      = 32
);
   logic                       req_valid;
   logic                       req_ready;
   logic [1:0]                 req_op;
   logic [DATA_WIDTH-1:0]      req_data;
   logic [1:0]                 req_width;
   logic [DATA_WIDTH-1:0]      req_noise;

   logic [AMBA_ADDR_WIDTH-1:0] paddr;
   logic [AMBA_WORD-1:0]       pwdata;
   logic                       psel;
   logic                       penable;
   logic                       pwrite;

   logic                       operation_done;
   logic [DATA_WIDTH-1:0]      data_out;
   logic [1:0]                 num_of_errors;

   logic                       rsp_valid;
   logic [DATA_WIDTH-1:0]      rsp_data;
   logic [1:0]                 rsp_num_of_errors;
   logic                       rsp_timeout;
   logic                       rsp_err;

   modport master (
      input  req_valid, req_op, req_data, req_width, req_noise,
      input  operation_done, data_out, num_of_errors,
      output req_ready,
      output paddr, pwdata, psel, penable, pwrite,
      output rsp_valid, rsp_data, rsp_num_of_errors, rsp_timeout, rsp_err
   );

   modport slave (
      output req_valid, req_op, req_data, req_width, req_noise,
      output operation_done, data_out, num_of_errors,
      input  req_ready,
      input  paddr, pwdata, psel, penable, pwrite,
      input  rsp_valid, rsp_data, rsp_num_of_errors, rsp_timeout, rsp_err
   );
endinterface

// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer
//   APB master that programs the ECC encoder/decoder for one request at a
//   time: DATA_IN (0x04), CODEWORD_WIDTH (0x08), NOISE (0x0C), then CTRL
//   (0x00) as the trigger. It then waits for operation_done (bounded by
//   TIMEOUT_CYCLES) and returns the result as a one-cycle response.
//
//   Ports
//     clk  : single clock, rising edge
//     rst  : synchronous, active-low reset
//     bus  : ecc_apb_sequencer_if.master (request, APB, ECC status, response)
//
//   Build option
//     ECC_SEQ_REG_CACHE_EN : remember the last written CODEWORD_WIDTH/NOISE
//                            and skip writes whose value is unchanged.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   ST_IDLE      | req_ready high, waiting for a request
//   ST_SETUP     | APB setup phase of the register selected by reg_sel_q
//   ST_ACCESS    | APB access phase of the same register (no pready)
//   ST_WAIT_DONE | CTRL written, waiting for operation_done or timeout
//   ST_RESP      | rsp_valid strobe, payload registers already loaded
module ecc_apb_sequencer #(
   parameter int AMBA_ADDR_WIDTH = 32,
   parameter int AMBA_WORD       = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input logic                  clk,
   input logic                  rst,
   ecc_apb_sequencer_if.master  bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_WAIT_DONE,
      ST_RESP
   } state_t;

   // Encoding doubles as the word index of the register address.
   typedef enum logic [1:0] {
      REG_CTRL  = 2'd0,
      REG_DATA  = 2'd1,
      REG_WIDTH = 2'd2,
      REG_NOISE = 2'd3
   } reg_sel_t;

   state_t                     state_q, state_d;
   reg_sel_t                   reg_sel_q, reg_sel_d;
   logic                       ready_q;

   logic [1:0]                 op_q;
   logic [DATA_WIDTH-1:0]      data_q;
   logic [1:0]                 width_q;
   logic [DATA_WIDTH-1:0]      noise_q;
   logic [CNT_W-1:0]           cnt_q;

   logic [DATA_WIDTH-1:0]      rsp_data_q;
   logic [1:0]                 rsp_num_q;
   logic                       rsp_timeout_q;
   logic                       rsp_err_q;

   logic                       accept;
   logic                       done_hit;
   logic                       timeout_hit;
   logic                       ctrl_written;
   logic                       skip_width;
   logic                       skip_noise;

   logic [AMBA_ADDR_WIDTH-1:0] paddr_c;
   logic [AMBA_WORD-1:0]       pwdata_c;
   logic                       psel_c;
   logic                       penable_c;
   logic                       pwrite_c;

   assign ctrl_written = (state_q == ST_ACCESS) && (reg_sel_q == REG_CTRL);

`ifdef ECC_SEQ_REG_CACHE_EN
   logic                       cache_valid_q;
   logic [1:0]                 cache_width_q;
   logic [DATA_WIDTH-1:0]      cache_noise_q;

   // Cache is committed only once CTRL is written, so both values are known
   // to be in the slave. A timeout leaves the slave state in doubt.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cache_valid_q <= 1'b0;
         cache_width_q <= '0;
         cache_noise_q <= '0;
      end else if (timeout_hit) begin
         cache_valid_q <= 1'b0;
      end else if (ctrl_written) begin
         cache_valid_q <= 1'b1;
         cache_width_q <= width_q;
         cache_noise_q <= noise_q;
      end
   end

   assign skip_width = cache_valid_q && (cache_width_q == width_q);
   assign skip_noise = cache_valid_q && (cache_noise_q == noise_q);
`else
   assign skip_width = 1'b0;
   assign skip_noise = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         reg_sel_q <= REG_DATA;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         reg_sel_q <= reg_sel_d;
         ready_q   <= (state_d == ST_IDLE);
      end
   end

   always_comb begin
      state_d     = state_q;
      reg_sel_d   = reg_sel_q;
      accept      = 1'b0;
      done_hit    = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // ready_q keeps the sequencer deaf for the first cycle after reset
            if (ready_q && bus.req_valid) begin
               accept = 1'b1;
               if (bus.req_op == 2'd0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d   = ST_SETUP;
                  reg_sel_d = REG_DATA;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            state_d = ST_SETUP;
            case (reg_sel_q)
               REG_DATA: begin
                  if (!skip_width) begin
                     reg_sel_d = REG_WIDTH;
                  end else if (!skip_noise) begin
                     reg_sel_d = REG_NOISE;
                  end else begin
                     reg_sel_d = REG_CTRL;
                  end
               end
               REG_WIDTH: begin
                  if (!skip_noise) begin
                     reg_sel_d = REG_NOISE;
                  end else begin
                     reg_sel_d = REG_CTRL;
                  end
               end
               REG_NOISE: begin
                  reg_sel_d = REG_CTRL;
               end
               default: begin
                  state_d = ST_WAIT_DONE;
               end
            endcase
         end
         ST_WAIT_DONE: begin
            // done takes priority over a simultaneous counter limit
            if (bus.operation_done) begin
               done_hit = 1'b1;
               state_d  = ST_RESP;
            end else if (cnt_q == CNT_LIMIT) begin
               timeout_hit = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q          <= '0;
         data_q        <= '0;
         width_q       <= '0;
         noise_q       <= '0;
         cnt_q         <= '0;
         rsp_data_q    <= '0;
         rsp_num_q     <= '0;
         rsp_timeout_q <= 1'b0;
         rsp_err_q     <= 1'b0;
      end else begin
         if (accept) begin
            op_q    <= bus.req_op;
            data_q  <= bus.req_data;
            width_q <= bus.req_width;
            noise_q <= bus.req_noise;
         end

         if (ctrl_written) begin
            cnt_q <= '0;
         end else if ((state_q == ST_WAIT_DONE) && (cnt_q != CNT_LIMIT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (accept && (bus.req_op == 2'd0)) begin
            rsp_data_q    <= '0;
            rsp_num_q     <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b1;
         end else if (done_hit) begin
            rsp_data_q    <= bus.data_out;
            rsp_num_q     <= bus.num_of_errors;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b0;
         end else if (timeout_hit) begin
            rsp_data_q    <= '0;
            rsp_num_q     <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_err_q     <= 1'b0;
         end
      end
   end

   always_comb begin
      psel_c    = 1'b0;
      penable_c = 1'b0;
      pwrite_c  = 1'b0;
      paddr_c   = '0;
      pwdata_c  = '0;
      if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) begin
         psel_c       = 1'b1;
         penable_c    = (state_q == ST_ACCESS);
         pwrite_c     = 1'b1;
         paddr_c[3:0] = {reg_sel_q, 2'b00};
         case (reg_sel_q)
            REG_DATA:  pwdata_c[DATA_WIDTH-1:0] = data_q;
            REG_WIDTH: pwdata_c[1:0]            = width_q;
            REG_NOISE: pwdata_c[DATA_WIDTH-1:0] = noise_q;
            default:   pwdata_c[1:0]            = op_q - 2'd1;
         endcase
      end
   end

   assign bus.req_ready         = ready_q;
   assign bus.paddr             = paddr_c;
   assign bus.pwdata            = pwdata_c;
   assign bus.psel              = psel_c;
   assign bus.penable           = penable_c;
   assign bus.pwrite            = pwrite_c;
   assign bus.rsp_valid         = (state_q == ST_RESP);
   assign bus.rsp_data          = rsp_data_q;
   assign bus.rsp_num_of_errors = rsp_num_q;
   assign bus.rsp_timeout       = rsp_timeout_q;
   assign bus.rsp_err           = rsp_err_q;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
module tb_ecc_apb_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ecc_apb_sequencer_if #(.AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .DATA_WIDTH(32)) bus ();

   ecc_apb_sequencer #(
      .AMBA_ADDR_WIDTH(32),
      .AMBA_WORD(32),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called in an IDLE cycle; returns in the first cycle after the accept edge.
   task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] data,
                        input logic [1:0] width, input logic [31:0] noise);
      chk({tag, " req_ready before"}, bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = data;
      bus.req_width = width;
      bus.req_noise = noise;
      step();
      bus.req_valid = 1'b0;
      bus.req_data  = 32'hFFFF_FFFF;
      bus.req_noise = 32'hFFFF_FFFF;
   endtask

   task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
      chk({tag, " setup psel"},    bus.psel, 1);
      chk({tag, " setup penable"}, bus.penable, 0);
      chk({tag, " setup pwrite"},  bus.pwrite, 1);
      chk({tag, " setup paddr"},   bus.paddr, addr);
      chk({tag, " setup pwdata"},  bus.pwdata, data);
      chk({tag, " setup ready"},   bus.req_ready, 0);
      step();
      chk({tag, " access psel"},    bus.psel, 1);
      chk({tag, " access penable"}, bus.penable, 1);
      chk({tag, " access paddr"},   bus.paddr, addr);
      chk({tag, " access pwdata"},  bus.pwdata, data);
      step();
   endtask

   task automatic expect_bus_idle(input string tag);
      chk({tag, " psel"},    bus.psel, 0);
      chk({tag, " penable"}, bus.penable, 0);
      chk({tag, " paddr"},   bus.paddr, 0);
      chk({tag, " pwdata"},  bus.pwdata, 0);
   endtask

   // Raises done in the current WAIT_DONE cycle; returns in the following IDLE cycle.
   task automatic finish_done(input string tag, input logic [31:0] dout, input logic [1:0] nerr);
      bus.operation_done = 1'b1;
      bus.data_out       = dout;
      bus.num_of_errors  = nerr;
      step();
      bus.operation_done = 1'b0;
      bus.data_out       = ~dout;
      bus.num_of_errors  = ~nerr;
      chk({tag, " rsp_valid"},   bus.rsp_valid, 1);
      chk({tag, " rsp_data"},    bus.rsp_data, dout);
      chk({tag, " rsp_nerr"},    bus.rsp_num_of_errors, nerr);
      chk({tag, " rsp_timeout"}, bus.rsp_timeout, 0);
      chk({tag, " rsp_err"},     bus.rsp_err, 0);
      chk({tag, " rsp ready"},   bus.req_ready, 0);
      step();
      chk({tag, " rsp_valid drop"}, bus.rsp_valid, 0);
      chk({tag, " ready back"},     bus.req_ready, 1);
      chk({tag, " rsp_data hold"},  bus.rsp_data, dout);
   endtask

   initial begin
      bus.req_valid      = 1'b0;
      bus.req_op         = 2'd0;
      bus.req_data       = '0;
      bus.req_width      = 2'd0;
      bus.req_noise      = '0;
      bus.operation_done = 1'b0;
      bus.data_out       = '0;
      bus.num_of_errors  = 2'd0;

      // reset
      step();
      chk("rst req_ready",   bus.req_ready, 0);
      chk("rst rsp_valid",   bus.rsp_valid, 0);
      chk("rst rsp_data",    bus.rsp_data, 0);
      chk("rst rsp_timeout", bus.rsp_timeout, 0);
      chk("rst rsp_err",     bus.rsp_err, 0);
      expect_bus_idle("rst");
      step();
      rst = 1'b1;
      chk("rst held ready", bus.req_ready, 0);
      step();
      chk("post rst ready", bus.req_ready, 1);

      // encode: done at T+12, response at T+13
      issue("enc", 2'd1, 32'h0000_005A, 2'd0, 32'h0);
      expect_write("enc data",  32'h04, 32'h5A);
      expect_write("enc width", 32'h08, 32'h0);
      expect_write("enc noise", 32'h0C, 32'h0);
      expect_write("enc ctrl",  32'h00, 32'h0);
      for (int i = 9; i < 12; i++) begin
         expect_bus_idle("enc wait");
         chk("enc wait rsp_valid", bus.rsp_valid, 0);
         step();
      end
      finish_done("enc", 32'h1234_56A5, 2'd0);

      // decode with one error, stale done during the write phase
      issue("dec", 2'd2, 32'h0000_ABCD, 2'd1, 32'h0000_0010);
      expect_write("dec data",  32'h04, 32'hABCD);
      bus.operation_done = 1'b1;
      bus.data_out       = 32'hDEAD_BEEF;
      bus.num_of_errors  = 2'd3;
      expect_write("dec width", 32'h08, 32'h1);
      bus.operation_done = 1'b0;
      expect_write("dec noise", 32'h0C, 32'h10);
      expect_write("dec ctrl",  32'h00, 32'h1);
      chk("dec stale rsp_valid 0", bus.rsp_valid, 0);
      step();
      chk("dec stale rsp_valid 1", bus.rsp_valid, 0);
      finish_done("dec", 32'h0000_00AB, 2'd1);

      // timeout: WAIT_DONE at T+9, response 9 cycles later
      issue("tmo", 2'd3, 32'h0000_0077, 2'd2, 32'h0000_0003);
      expect_write("tmo data",  32'h04, 32'h77);
      expect_write("tmo width", 32'h08, 32'h2);
      expect_write("tmo noise", 32'h0C, 32'h3);
      expect_write("tmo ctrl",  32'h00, 32'h2);
      for (int i = 0; i < 9; i++) begin
         chk("tmo wait rsp_valid", bus.rsp_valid, 0);
         step();
      end
      chk("tmo rsp_valid",   bus.rsp_valid, 1);
      chk("tmo rsp_timeout", bus.rsp_timeout, 1);
      chk("tmo rsp_data",    bus.rsp_data, 0);
      chk("tmo rsp_nerr",    bus.rsp_num_of_errors, 0);
      chk("tmo rsp_err",     bus.rsp_err, 0);
      step();
      chk("tmo rsp_valid drop", bus.rsp_valid, 0);
      chk("tmo rsp_timeout hold", bus.rsp_timeout, 1);

      // op 0: immediate error response, no APB traffic
      issue("op0", 2'd0, 32'h0000_0099, 2'd0, 32'h0);
      chk("op0 rsp_valid",   bus.rsp_valid, 1);
      chk("op0 rsp_err",     bus.rsp_err, 1);
      chk("op0 rsp_timeout", bus.rsp_timeout, 0);
      expect_bus_idle("op0 resp");
      step();
      chk("op0 rsp_valid drop", bus.rsp_valid, 0);
      chk("op0 ready", bus.req_ready, 1);
      expect_bus_idle("op0 idle");

      // reset during NOISE ACCESS
      issue("rma", 2'd1, 32'h0000_0011, 2'd0, 32'h0);
      expect_write("rma data",  32'h04, 32'h11);
      expect_write("rma width", 32'h08, 32'h0);
      chk("rma noise setup paddr", bus.paddr, 32'h0C);
      step();
      chk("rma noise access penable", bus.penable, 1);
      rst = 1'b0;
      step();
      chk("rma psel",      bus.psel, 0);
      chk("rma penable",   bus.penable, 0);
      chk("rma req_ready", bus.req_ready, 0);
      chk("rma rsp_valid", bus.rsp_valid, 0);
      rst = 1'b1;
      step();
      chk("rma ready after", bus.req_ready, 1);
      chk("rma rsp_valid after", bus.rsp_valid, 0);
      issue("full", 2'd1, 32'h0000_0022, 2'd3, 32'h0000_0005);
      expect_write("full data",  32'h04, 32'h22);
      expect_write("full width", 32'h08, 32'h3);
      expect_write("full noise", 32'h0C, 32'h5);
      expect_write("full ctrl",  32'h00, 32'h0);
      expect_bus_idle("full wait");
      finish_done("full", 32'h0000_0099, 2'd2);

`ifdef ECC_SEQ_REG_CACHE_EN
      // same width and noise: only DATA_IN and CTRL
      issue("c2", 2'd2, 32'h0000_0033, 2'd3, 32'h0000_0005);
      expect_write("c2 data", 32'h04, 32'h33);
      expect_write("c2 ctrl", 32'h00, 32'h1);
      expect_bus_idle("c2 wait");
      finish_done("c2", 32'h0000_0044, 2'd0);
      // new noise: NOISE written again
      issue("c3", 2'd3, 32'h0000_0055, 2'd3, 32'h0000_0006);
      expect_write("c3 data",  32'h04, 32'h55);
      expect_write("c3 noise", 32'h0C, 32'h6);
      expect_write("c3 ctrl",  32'h00, 32'h2);
      expect_bus_idle("c3 wait");
      finish_done("c3", 32'h0000_0066, 2'd1);
`else
      // repeated width and noise still produce all four writes
      issue("r2", 2'd2, 32'h0000_0033, 2'd3, 32'h0000_0005);
      expect_write("r2 data",  32'h04, 32'h33);
      expect_write("r2 width", 32'h08, 32'h3);
      expect_write("r2 noise", 32'h0C, 32'h5);
      expect_write("r2 ctrl",  32'h00, 32'h1);
      expect_bus_idle("r2 wait");
      finish_done("r2", 32'h0000_0044, 2'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
